// File: rtl/countdown_timer_bcd_pkg.sv
// Shared types and constants for the BCD countdown timer: state encoding,
// active-low 7-segment table and the compile-time binary-to-BCD helper.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Segments g..a, active low; entry 9 first so index n holds digit n.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    if (digit <= 4'd9) begin
      seg = SEG_TABLE[digit];
    end else begin
      seg = SEG_BLANK;
    end
    return seg;
  endfunction

  function automatic logic [15:0] bin2bcd(input int value, input int ndigits);
    logic [15:0] res;
    int          v;
    res = 16'd0;
    v   = value;
    for (int i = 0; i < 4; i++) begin
      if (i < ndigits) begin
        res[i*4 +: 4] = 4'(v % 10);
        v             = v / 10;
      end else begin
        res[i*4 +: 4] = 4'd0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/countdown_timer_bcd_tick_prescaler.sv
// Free-running divider that emits a one-cycle tick every TICK_DIV enabled
// cycles; holds its count while disabled so a paused timer resumes mid-period.
module tick_prescaler
  import countdown_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input  logic Clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign tick = en && (r_cnt == LAST);

  // Period counter; clear has priority, wraps to zero on the tick edge.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/countdown_timer_bcd.sv
// N-digit BCD countdown timer with load/start/pause, optional auto-reload,
// registered status flags and active-low 7-segment outputs per digit.
module countdown_timer_bcd
  import countdown_pkg::*;
#(
  parameter int TICK_DIV    = 50000000,
  parameter int NUM_DIGITS  = 2,
  parameter int START_VALUE = 30,
  parameter int AUTO_RELOAD = 0,
  parameter int BLANK_LZ    = 0
) (
  input  logic                    Clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    start,
  input  logic                    pause,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [7*NUM_DIGITS-1:0] display,
  output logic                    running,
  output logic                    time_out
);

  localparam int           W         = 4 * NUM_DIGITS;
  localparam logic [W-1:0] START_BCD = W'(bin2bcd(START_VALUE, NUM_DIGITS));
  localparam logic [W-1:0] BCD_ONE   = W'(1);

  function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[i*4 +: 4] > 4'd9) begin
        r[i*4 +: 4] = 4'd9;
      end else begin
        r[i*4 +: 4] = v[i*4 +: 4];
      end
    end
    return r;
  endfunction

  // Ripple-borrow decrement that saturates at zero.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = (v != '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (borrow && (v[i*4 +: 4] == 4'd0)) begin
        r[i*4 +: 4] = 4'd9;
      end else if (borrow) begin
        r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
        borrow      = 1'b0;
      end else begin
        r[i*4 +: 4] = v[i*4 +: 4];
      end
    end
    return r;
  endfunction

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] r_count;
  logic [W-1:0] w_count_nxt;
  logic         r_running;
  logic         r_time_out;
  logic         w_reload;
  logic         w_tick;
  logic         w_pre_en;
  logic         w_pre_clr;

  assign w_pre_en  = (r_state == RUN) && !load && !pause;
  assign w_pre_clr = load || ((r_state == IDLE) && start);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .Clk (Clk),
    .rst (rst),
    .en  (w_pre_en),
    .clr (w_pre_clr),
    .tick(w_tick)
  );

  // State, count and status registers.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_count    <= START_BCD;
      r_running  <= 1'b0;
      r_time_out <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_running  <= (w_state_nxt == RUN);
      r_time_out <= (w_state_nxt == EXPIRED) || w_reload;
    end
  end

  // Next-state and next-count; load overrides every state.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_reload    = 1'b0;
    if (load) begin
      w_count_nxt = clamp_bcd(load_value);
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            w_state_nxt = (r_count != '0) ? RUN : EXPIRED;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        RUN: begin
          if (pause) begin
            w_state_nxt = PAUSED;
          end else if (w_tick && (r_count == BCD_ONE)) begin
            if (AUTO_RELOAD != 0) begin
              w_count_nxt = START_BCD;
              w_reload    = 1'b1;
            end else begin
              w_count_nxt = '0;
              w_state_nxt = EXPIRED;
            end
          end else if (w_tick) begin
            w_count_nxt = bcd_dec(r_count);
          end else begin
            w_state_nxt = RUN;
          end
        end
        PAUSED: begin
          if (start) begin
            w_state_nxt = RUN;
          end else begin
            w_state_nxt = PAUSED;
          end
        end
        EXPIRED: w_state_nxt = EXPIRED;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Segment decode, scanning from the top digit to track leading zeros.
  always_comb begin : seg_blk
    logic w_lead_zero;
    w_lead_zero = 1'b1;
    display     = '1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if ((BLANK_LZ != 0) && (i != 0) && w_lead_zero && (r_count[i*4 +: 4] == 4'd0)) begin
        display[i*7 +: 7] = SEG_BLANK;
      end else begin
        display[i*7 +: 7] = seg_decode(r_count[i*4 +: 4]);
      end
      if (r_count[i*4 +: 4] != 4'd0) begin
        w_lead_zero = 1'b0;
      end else begin
        w_lead_zero = w_lead_zero;
      end
    end
  end

  assign bcd_out  = r_count;
  assign running  = r_running;
  assign time_out = r_time_out;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Self-checking bench: three timer variants (plain, auto-reload, blanking)
// share stimulus; expectations flow through a scoreboard queue.
module tb_countdown_timer_bcd;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;

  logic        Clk = 1'b0;
  logic        rst;
  logic        load;
  logic [7:0]  load_value;
  logic        start;
  logic        pause;
  logic [7:0]  bcd_a, bcd_b, bcd_c;
  logic [13:0] disp_a, disp_b, disp_c;
  logic        run_a, run_b, run_c;
  logic        to_a, to_b, to_c;

  always #5 Clk = ~Clk;

  countdown_timer_bcd #(.TICK_DIV(4), .NUM_DIGITS(2), .START_VALUE(30), .AUTO_RELOAD(0), .BLANK_LZ(0)) dut_a (
    .Clk(Clk), .rst(rst), .load(load), .load_value(load_value), .start(start), .pause(pause),
    .bcd_out(bcd_a), .display(disp_a), .running(run_a), .time_out(to_a));

  countdown_timer_bcd #(.TICK_DIV(4), .NUM_DIGITS(2), .START_VALUE(30), .AUTO_RELOAD(1), .BLANK_LZ(0)) dut_b (
    .Clk(Clk), .rst(rst), .load(load), .load_value(load_value), .start(start), .pause(pause),
    .bcd_out(bcd_b), .display(disp_b), .running(run_b), .time_out(to_b));

  countdown_timer_bcd #(.TICK_DIV(4), .NUM_DIGITS(2), .START_VALUE(30), .AUTO_RELOAD(0), .BLANK_LZ(1)) dut_c (
    .Clk(Clk), .rst(rst), .load(load), .load_value(load_value), .start(start), .pause(pause),
    .bcd_out(bcd_c), .display(disp_c), .running(run_c), .time_out(to_c));

  typedef struct {
    logic       ld;
    logic [7:0] lv;
    logic       st;
    logic       pa;
    logic [7:0] bcd;
    logic       run;
    logic       to;
  } vec_t;

  typedef struct {
    int         sel;
    logic [7:0] bcd;
    logic       run;
    logic       to;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of strobes, queue the expectation, compare after the edge.
  task automatic step(input int sel, input logic ld, input logic [7:0] lv, input logic st,
                      input logic pa, input logic [7:0] e_bcd, input logic e_run,
                      input logic e_to, input string name);
    exp_t       e;
    logic [7:0] ab;
    logic       ar, at;
    load = ld; load_value = lv; start = st; pause = pa;
    sb_q.push_back('{sel, e_bcd, e_run, e_to});
    @(posedge Clk);
    #1;
    load = 1'b0; start = 1'b0; pause = 1'b0;
    e = sb_q.pop_front();
    if (e.sel == 1) begin
      ab = bcd_b; ar = run_b; at = to_b;
    end else if (e.sel == 2) begin
      ab = bcd_c; ar = run_c; at = to_c;
    end else begin
      ab = bcd_a; ar = run_a; at = to_a;
    end
    chk({name, " bcd"}, 32'(ab), 32'(e.bcd));
    chk({name, " running"}, 32'(ar), 32'(e.run));
    chk({name, " time_out"}, 32'(at), 32'(e.to));
  endtask

  task automatic idle(input int sel, input logic [7:0] e_bcd, input logic e_run,
                      input logic e_to, input string name);
    step(sel, 1'b0, 8'h00, 1'b0, 1'b0, e_bcd, e_run, e_to, name);
  endtask

  initial begin
    vec_t tbl[5];
    int   val;

    tbl[0] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h30, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h30, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h30, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h30, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h29, 1'b1, 1'b0};

    rst = 1'b1; load = 1'b0; load_value = 8'h00; start = 1'b0; pause = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    rst = 1'b0;

    chk("reset bcd", 32'(bcd_a), 32'(8'h30));
    chk("reset running", 32'(run_a), 32'(1'b0));
    chk("reset time_out", 32'(to_a), 32'(1'b0));
    chk("reset display", 32'(disp_a), 32'({S3, S0}));
    chk("reset display blank variant", 32'(disp_c), 32'({S3, S0}));

    // Start and first decrement exactly four cycles later.
    for (int i = 0; i < 5; i++) begin
      step(0, tbl[i].ld, tbl[i].lv, tbl[i].st, tbl[i].pa, tbl[i].bcd, tbl[i].run, tbl[i].to,
           $sformatf("vec%0d", i));
    end
    chk("display 29", 32'(disp_a), 32'({S2, S9}));

    // Count down to expiry, including the 10 -> 09 borrow.
    for (int k = 5; k <= 120; k++) begin
      val = 30 - (k / 4);
      idle(0, to_bcd(val), (val != 0), (val == 0), $sformatf("rundown%0d", k));
    end
    chk("expired display", 32'(disp_a), 32'({S0, S0}));
    step(0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, "start in expired");
    step(0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, "pause in expired");

    // Pause mid-period, resume with the remaining prescaler cycles.
    step(0, 1'b1, 8'h26, 1'b0, 1'b0, 8'h26, 1'b0, 1'b0, "load 26");
    step(0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h26, 1'b1, 1'b0, "start 26");
    repeat (3) idle(0, 8'h26, 1'b1, 1'b0, "run 26");
    idle(0, 8'h25, 1'b1, 1'b0, "tick 25");
    repeat (2) idle(0, 8'h25, 1'b1, 1'b0, "run 25");
    step(0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h25, 1'b0, 1'b0, "pause 25");
    repeat (20) idle(0, 8'h25, 1'b0, 1'b0, "paused hold");
    step(0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h25, 1'b1, 1'b0, "resume");
    idle(0, 8'h25, 1'b1, 1'b0, "resume +1");
    idle(0, 8'h24, 1'b1, 1'b0, "resume +2 tick");

    // Load wins over start, digits clamp; zero start expires.
    step(0, 1'b1, 8'h3F, 1'b1, 1'b0, 8'h39, 1'b0, 1'b0, "load beats start");
    idle(0, 8'h39, 1'b0, 1'b0, "idle 39");
    step(0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h39, 1'b0, 1'b0, "pause in idle");
    step(0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "load 00");
    chk("blank zero keeps digit0", 32'(disp_c), 32'({SB, S0}));
    step(0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, "start at zero");
    idle(0, 8'h00, 1'b0, 1'b1, "zero expired hold");

    // Auto-reload variant: one-cycle time_out pulse, keeps running.
    step(1, 1'b1, 8'h02, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, "ar load 02");
    step(1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h02, 1'b1, 1'b0, "ar start");
    repeat (3) idle(1, 8'h02, 1'b1, 1'b0, "ar run 02");
    idle(1, 8'h01, 1'b1, 1'b0, "ar tick 01");
    repeat (3) idle(1, 8'h01, 1'b1, 1'b0, "ar run 01");
    idle(1, 8'h30, 1'b1, 1'b1, "ar reload");
    idle(1, 8'h30, 1'b1, 1'b0, "ar pulse end");
    idle(1, 8'h30, 1'b1, 1'b0, "ar after reload");

    // Leading-zero blanking.
    step(2, 1'b1, 8'h05, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0, "load 05");
    chk("blank 05", 32'(disp_c), 32'({SB, S5}));
    chk("no blank 05", 32'(disp_a), 32'({S0, S5}));

    // Asynchronous reset mid-run, observed before the next edge.
    step(0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h05, 1'b1, 1'b0, "start 05");
    idle(0, 8'h05, 1'b1, 1'b0, "run 05");
    #2;
    rst = 1'b1;
    #1;
    chk("async rst bcd", 32'(bcd_a), 32'(8'h30));
    chk("async rst running", 32'(run_a), 32'(1'b0));
    chk("async rst time_out", 32'(to_a), 32'(1'b0));
    chk("async rst display", 32'(disp_a), 32'({S3, S0}));
    chk("async rst ar running", 32'(run_b), 32'(1'b0));
    #2;
    rst = 1'b0;
    idle(0, 8'h30, 1'b0, 1'b0, "after rst idle");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
